counter_seq_ctrl: RTL and testbench

- Sequencer/controller for the team's WIDTH-bit counter datapath.
- Loads a programmed start value and counts it down at a prescaled rate.
- Flags terminal count, then either stops (one-shot) or reloads (auto-reload).
- Sits between the control/config interface and the counter, exposing busy/done/terminal-count status to the rest of the design.

---
 rtl/counter_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// counter_seq_ctrl : load / prescaled count-down / terminal-count sequencer
// Rev 1.0
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic             cfg_mode,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] C_PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   cnt_q,     cnt_d;
    logic [PRE_W-1:0]   pre_q,     pre_d;
    logic [WIDTH-1:0]   sh_load_q, sh_load_d;
    logic [PRE_W-1:0]   sh_pre_q,  sh_pre_d;
    logic               sh_mode_q, sh_mode_d;
    logic               busy_q,    busy_d;
    logic               tc_q,      tc_d;
    logic               done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        sh_load_d = sh_load_q;
        sh_pre_d  = sh_pre_q;
        sh_mode_d = sh_mode_q;
        busy_d    = busy_q;
        tc_d      = 1'b0;
        done_d    = done_q;

        if (stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (start) begin
            // Any start (fresh or restart) recaptures config and suppresses a coincident terminal tick.
            state_d   = S_LOAD;
            sh_load_d = cfg_load;
            sh_pre_d  = cfg_pre;
            sh_mode_d = cfg_mode;
            pre_d     = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    cnt_d   = sh_load_q;
                    pre_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
                S_RUN: begin
                    if (pre_q == sh_pre_q) begin
                        pre_d = '0;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - C_CNT_ONE;
                        end else begin
                            tc_d = 1'b1;
                            if (sh_mode_q) begin
                                cnt_d = sh_load_q;
                            end else begin
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + C_PRE_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            sh_load_q <= '0;
            sh_pre_q  <= '0;
            sh_mode_q <= 1'b0;
            busy_q    <= 1'b0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            sh_load_q <= sh_load_d;
            sh_pre_q  <= sh_pre_d;
            sh_mode_q <= sh_mode_d;
            busy_q    <= busy_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

    assign cnt_out  = cnt_q;
    assign busy     = busy_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_counter_seq_ctrl : randomized + directed bench against a closed-form model
// Rev 1.0
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] cfg_load;
    logic [PRE_W-1:0] cfg_pre;
    logic             cfg_mode;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             tc_pulse;
    logic             done;

    counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .cfg_load (cfg_load),
        .cfg_pre  (cfg_pre),
        .cfg_mode (cfg_mode),
        .cnt_out  (cnt_out),
        .busy     (busy),
        .tc_pulse (tc_pulse),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: output is a closed-form function of clocks elapsed since the last start.
    bit m_active;
    int m_cyc, m_t0, m_L, m_p, m_mode;
    int e_cnt, e_busy, e_tc, e_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_cyc    = 0;
        m_t0     = 0;
        e_cnt    = 0;
        e_busy   = 0;
        e_tc     = 0;
        e_done   = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input int ld, input int pr, input bit md);
        int m, q, per, mm;
        m_cyc++;
        e_tc = 0;
        if (sp) begin
            m_active = 1'b0;
            e_busy   = 0;
            e_done   = 0;
        end else if (st) begin
            m_active = 1'b1;
            m_t0     = m_cyc;
            m_L      = ld;
            m_p      = pr;
            m_mode   = md;
            e_busy   = 1;
            e_done   = 0;
        end else if (m_active) begin
            m   = m_cyc - m_t0 - 1;
            q   = m_p + 1;
            per = (m_L + 1) * q;
            if (m_mode == 0 && m >= per) begin
                e_cnt  = 0;
                e_busy = 0;
                e_done = 1;
                e_tc   = (m == per) ? 1 : 0;
            end else begin
                mm     = (m_mode == 1) ? (m % per) : m;
                e_cnt  = m_L - mm / q;
                e_busy = 1;
                e_tc   = (m_mode == 1 && m > 0 && mm == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("cnt_out",  32'(cnt_out),  32'(e_cnt));
        check_val("busy",     32'(busy),     32'(e_busy));
        check_val("tc_pulse", 32'(tc_pulse), 32'(e_tc));
        check_val("done",     32'(done),     32'(e_done));
    endtask

    task automatic step(input bit st, input bit sp, input int ld, input int pr, input bit md);
        @(negedge clk);
        start    = st;
        stop     = sp;
        cfg_load = WIDTH'(ld);
        cfg_pre  = PRE_W'(pr);
        cfg_mode = md;
        @(posedge clk);
        model_edge(st, sp, ld, pr, md);
        #1;
        check_outputs();
    endtask

    // Idle edges with scrambled cfg so that post-capture config changes are exercised.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
        end
    endtask

    task automatic run_until_cnt(input int target);
        int guard = 0;
        while (e_cnt != target && guard < 200) begin
            idle(1);
            guard++;
        end
        if (e_cnt != target) begin
            check_val("wait_cnt_timeout", 32'(guard), 32'(0));
        end
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        cfg_load = '0;
        cfg_pre  = '0;
        cfg_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 0, 1'b0);

        // One-shot, load=3, pre=0
        step(1'b1, 1'b0, 3, 0, 1'b0);
        idle(8);

        // Auto-reload, load=2, pre=1
        step(1'b1, 1'b0, 2, 1, 1'b1);
        idle(20);

        // Stop mid-run at cnt_out=9, then restart from 15
        step(1'b1, 1'b0, 15, 0, 1'b0);
        run_until_cnt(9);
        step(1'b0, 1'b1, 0, 0, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 15, 0, 1'b0);
        idle(3);

        // start+stop together in RUN
        step(1'b1, 1'b1, 7, 0, 1'b0);
        idle(3);

        // start coinciding with every-cycle terminal tick
        step(1'b1, 1'b0, 0, 0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 0, 0, 1'b0);

        // Async reset between edges while cnt_out=5
        step(1'b1, 1'b0, 9, 0, 1'b0);
        run_until_cnt(5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rstn = 1'b1;
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, ($urandom % 48) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
